table_access_ctrl: RTL and testbench

TABLE_ACCESS_CTRL -- requirements
Module: table_access_ctrl

---
 rtl/table_access_ctrl.sv | 247 ++++++++++++++++++++++++
 tb/tb_table_access_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/table_access_ctrl.sv
// table_access_ctrl: arbitrates a save channel and a lookup channel onto a
// single code table. Operands are latched at grant time, the table enable is
// held until the matching completion arrives, then the granted channel is
// acknowledged with a one-cycle pulse (err flags a failed operation).
//
// Optional feature: define TABLE_CTRL_TIMEOUT_EN to abort a SAVE/LOOK that
// waits TIMEOUT_CYCLES busy cycles without its completion (ack + err).
//
// Handshake: a requester raises sv_req/lk_req with stable operands and keeps
// it high until it sees its ack pulse. The ack is high only while the FSM is
// in DONE, so a request still high in that cycle is not re-granted. Lookup
// data on lk_char is valid from the ack cycle until the next lookup finishes.
module table_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        n_rst,
  // save channel
  input  logic        sv_req,
  input  logic [7:0]  sv_char,
  input  logic [11:0] sv_path,
  input  logic [3:0]  sv_len,
  output logic        sv_ack,
  // lookup channel
  input  logic        lk_req,
  input  logic [11:0] lk_loc,
  input  logic [3:0]  lk_len,
  output logic        lk_ack,
  output logic [7:0]  lk_char,
  output logic        err,
  // table side
  output logic [3:0]  length,
  output logic [7:0]  charIn,
  output logic [11:0] path,
  output logic        enableIn,
  output logic [3:0]  lengthOut,
  output logic [11:0] location,
  output logic        enableOut,
  input  logic        saveComp,
  input  logic        writeComp,
  input  logic [7:0]  charOut,
  // status / debug
  output logic        busy,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, SAVE = 2'd1, LOOK = 2'd2, DONE = 2'd3} state_t;

  state_t      state, state_nx;
  logic        op_lk, op_lk_nx;          // granted channel: 1 = lookup
  logic [7:0]  op_char, op_char_nx;
  logic [11:0] op_addr, op_addr_nx;      // path for saves, location for lookups
  logic [3:0]  op_len, op_len_nx;
  logic        fail, fail_nx;            // operation will finish with err
  logic        last_lk, last_lk_nx;      // last grant went to lookup
  logic        sv_ack_q, sv_ack_nx;
  logic        lk_ack_q, lk_ack_nx;
  logic        err_q, err_nx;
  logic        en_in_q, en_in_nx;
  logic        en_out_q, en_out_nx;
  logic [7:0]  lk_char_q, lk_char_nx;
  logic        grant_sv, grant_lk;

`ifdef TABLE_CTRL_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_cnt, wait_cnt_nx;
`else
  logic [7:0] unused_timeout;
  assign unused_timeout = 8'(TIMEOUT_CYCLES);
`endif

  // Code lengths 1..12 address the table; anything else is rejected.
  function automatic logic len_ok(input logic [3:0] l);
    return (l != 4'd0) && (l <= 4'd12);
  endfunction

  // State and registered outputs; reset aborts any operation without an ack.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      op_lk     <= 1'b0;
      op_char   <= 8'h00;
      op_addr   <= 12'h000;
      op_len    <= 4'h0;
      fail      <= 1'b0;
      last_lk   <= 1'b1;
      sv_ack_q  <= 1'b0;
      lk_ack_q  <= 1'b0;
      err_q     <= 1'b0;
      en_in_q   <= 1'b0;
      en_out_q  <= 1'b0;
      lk_char_q <= 8'h00;
`ifdef TABLE_CTRL_TIMEOUT_EN
      wait_cnt  <= 8'h00;
`endif
    end else begin
      state     <= state_nx;
      op_lk     <= op_lk_nx;
      op_char   <= op_char_nx;
      op_addr   <= op_addr_nx;
      op_len    <= op_len_nx;
      fail      <= fail_nx;
      last_lk   <= last_lk_nx;
      sv_ack_q  <= sv_ack_nx;
      lk_ack_q  <= lk_ack_nx;
      err_q     <= err_nx;
      en_in_q   <= en_in_nx;
      en_out_q  <= en_out_nx;
      lk_char_q <= lk_char_nx;
`ifdef TABLE_CTRL_TIMEOUT_EN
      wait_cnt  <= wait_cnt_nx;
`endif
    end
  end

  // Next-state, arbitration and next values of the registered outputs.
  always_comb begin
    state_nx   = state;
    op_lk_nx   = op_lk;
    op_char_nx = op_char;
    op_addr_nx = op_addr;
    op_len_nx  = op_len;
    fail_nx    = fail;
    last_lk_nx = last_lk;
    sv_ack_nx  = 1'b0;
    lk_ack_nx  = 1'b0;
    err_nx     = 1'b0;
    en_in_nx   = 1'b0;
    en_out_nx  = 1'b0;
    lk_char_nx = lk_char_q;
    grant_sv   = 1'b0;
    grant_lk   = 1'b0;
`ifdef TABLE_CTRL_TIMEOUT_EN
    wait_cnt_nx = wait_cnt;
`endif

    case (state)
      IDLE: begin
        // Round-robin: on contention the channel not served last wins.
        grant_sv = sv_req && (!lk_req || last_lk);
        grant_lk = lk_req && !grant_sv;
`ifdef TABLE_CTRL_TIMEOUT_EN
        wait_cnt_nx = 8'h00;
`endif
        if (grant_sv) begin
          op_lk_nx   = 1'b0;
          op_char_nx = sv_char;
          op_addr_nx = sv_path;
          op_len_nx  = sv_len;
          last_lk_nx = 1'b0;
          if (len_ok(sv_len)) begin
            state_nx = SAVE;
            fail_nx  = 1'b0;
            en_in_nx = 1'b1;
          end else begin
            state_nx = DONE;
            fail_nx  = 1'b1;
          end
        end else if (grant_lk) begin
          op_lk_nx   = 1'b1;
          op_char_nx = 8'h00;
          op_addr_nx = lk_loc;
          op_len_nx  = lk_len;
          last_lk_nx = 1'b1;
          if (len_ok(lk_len)) begin
            state_nx  = LOOK;
            fail_nx   = 1'b0;
            en_out_nx = 1'b1;
          end else begin
            state_nx   = DONE;
            fail_nx    = 1'b1;
            lk_char_nx = 8'h00;
          end
        end
      end

      SAVE: begin
        if (saveComp) begin
          state_nx = DONE;
        end
`ifdef TABLE_CTRL_TIMEOUT_EN
        else if (wait_cnt == TIMEOUT_LAST) begin
          state_nx = DONE;
          fail_nx  = 1'b1;
        end else begin
          en_in_nx    = 1'b1;
          wait_cnt_nx = wait_cnt + 8'd1;
        end
`else
        else begin
          en_in_nx = 1'b1;
        end
`endif
      end

      LOOK: begin
        if (writeComp) begin
          state_nx   = DONE;
          lk_char_nx = charOut;
        end
`ifdef TABLE_CTRL_TIMEOUT_EN
        else if (wait_cnt == TIMEOUT_LAST) begin
          state_nx   = DONE;
          fail_nx    = 1'b1;
          lk_char_nx = 8'h00;
        end else begin
          en_out_nx   = 1'b1;
          wait_cnt_nx = wait_cnt + 8'd1;
        end
`else
        else begin
          en_out_nx = 1'b1;
        end
`endif
      end

      DONE: begin
        // First DONE cycle arms the ack; the cycle the ack is visible
        // returns to IDLE, so a held request is never re-granted early.
        if (sv_ack_q || lk_ack_q) begin
          state_nx = IDLE;
        end else begin
          sv_ack_nx = !op_lk;
          lk_ack_nx = op_lk;
          err_nx    = fail;
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  assign sv_ack    = sv_ack_q;
  assign lk_ack    = lk_ack_q;
  assign err       = err_q;
  assign lk_char   = lk_char_q;
  assign enableIn  = en_in_q;
  assign enableOut = en_out_q;
  assign length    = en_in_q  ? op_len  : 4'h0;
  assign charIn    = en_in_q  ? op_char : 8'h00;
  assign path      = en_in_q  ? op_addr : 12'h000;
  assign lengthOut = en_out_q ? op_len  : 4'h0;
  assign location  = en_out_q ? op_addr : 12'h000;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_table_access_ctrl.sv
// Directed bench for table_access_ctrl: save, lookup, bad lengths,
// round-robin contention, reset during LOOK and (when built with
// TABLE_CTRL_TIMEOUT_EN) the wait timeout. Expected values are hand-derived.
module tb_table_access_ctrl;

  logic        clk;
  logic        n_rst;
  logic        sv_req;
  logic [7:0]  sv_char;
  logic [11:0] sv_path;
  logic [3:0]  sv_len;
  logic        sv_ack;
  logic        lk_req;
  logic [11:0] lk_loc;
  logic [3:0]  lk_len;
  logic        lk_ack;
  logic [7:0]  lk_char;
  logic        err;
  logic [3:0]  length;
  logic [7:0]  charIn;
  logic [11:0] path;
  logic        enableIn;
  logic [3:0]  lengthOut;
  logic [11:0] location;
  logic        enableOut;
  logic        saveComp;
  logic        writeComp;
  logic [7:0]  charOut;
  logic        busy;
  logic [1:0]  state_dbg;

  int n_cmp;
  int n_bad;

  logic [0:0] exp_q[$];   // expected grant order: 0 = save, 1 = lookup

  table_access_ctrl #(.TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .n_rst(n_rst),
    .sv_req(sv_req), .sv_char(sv_char), .sv_path(sv_path), .sv_len(sv_len), .sv_ack(sv_ack),
    .lk_req(lk_req), .lk_loc(lk_loc), .lk_len(lk_len), .lk_ack(lk_ack), .lk_char(lk_char),
    .err(err),
    .length(length), .charIn(charIn), .path(path), .enableIn(enableIn),
    .lengthOut(lengthOut), .location(location), .enableOut(enableOut),
    .saveComp(saveComp), .writeComp(writeComp), .charOut(charOut),
    .busy(busy), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver helpers: advance one edge, land 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  initial begin
    int overlap;
    int acks_seen;
    int cyc;
    logic prev_in, prev_out, got;

    n_cmp = 0; n_bad = 0;
    n_rst = 1'b0;
    sv_req = 1'b0; sv_char = 8'h00; sv_path = 12'h000; sv_len = 4'h0;
    lk_req = 1'b0; lk_loc = 12'h000; lk_len = 4'h0;
    saveComp = 1'b0; writeComp = 1'b0; charOut = 8'h00;

    // reset state
    #2;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_en_in", enableIn, 0);
    check_eq("rst_en_out", enableOut, 0);
    check_eq("rst_lk_char", lk_char, 0);
    check_eq("rst_acks", {sv_ack, lk_ack, err}, 0);
    tick();
    tick();
    n_rst = 1'b1;

    // save: granted on first edge after reset release, comp after 2 cycles
    sv_req = 1'b1; sv_char = 8'h41; sv_path = 12'h005; sv_len = 4'd3;
    tick();
    check_eq("sv_en_c1", enableIn, 1);
    check_eq("sv_path", path, 12'h005);
    check_eq("sv_char", charIn, 8'h41);
    check_eq("sv_len", length, 3);
    check_eq("sv_busy", busy, 1);
    check_eq("sv_no_en_out", enableOut, 0);
    tick();
    check_eq("sv_en_c2", enableIn, 1);
    saveComp = 1'b1;
    tick();
    check_eq("sv_en_drop", enableIn, 0);
    check_eq("sv_ack_early", sv_ack, 0);
    saveComp = 1'b0;
    tick();
    check_eq("sv_ack", sv_ack, 1);
    check_eq("sv_err", err, 0);
    sv_req = 1'b0;
    tick();
    check_eq("sv_ack_pulse", sv_ack, 0);
    check_eq("sv_idle", busy, 0);

    // lookup: operand change while busy must not matter
    lk_req = 1'b1; lk_loc = 12'h00A; lk_len = 4'd4;
    tick();
    check_eq("lk_en_out", enableOut, 1);
    check_eq("lk_loc", location, 12'h00A);
    check_eq("lk_len", lengthOut, 4);
    check_eq("lk_no_en_in", enableIn, 0);
    writeComp = 1'b1; charOut = 8'h5A; lk_loc = 12'h0FF;
    tick();
    check_eq("lk_char_cap", lk_char, 8'h5A);
    check_eq("lk_en_drop", enableOut, 0);
    writeComp = 1'b0; charOut = 8'h00;
    tick();
    check_eq("lk_ack", lk_ack, 1);
    check_eq("lk_err", err, 0);
    lk_req = 1'b0;
    tick();
    check_eq("lk_ack_pulse", lk_ack, 0);
    check_eq("lk_char_hold", lk_char, 8'h5A);

    // bad save length 0: no table access, ack+err two edges after grant edge
    sv_req = 1'b1; sv_len = 4'd0;
    tick();
    check_eq("bad_sv_no_en", enableIn, 0);
    check_eq("bad_sv_busy", busy, 1);
    check_eq("bad_sv_ack_early", sv_ack, 0);
    tick();
    check_eq("bad_sv_ack", sv_ack, 1);
    check_eq("bad_sv_err", err, 1);
    sv_req = 1'b0;
    tick();
    check_eq("bad_sv_err_pulse", err, 0);

    // bad lookup length 13: lk_char cleared
    lk_req = 1'b1; lk_len = 4'd13;
    tick();
    check_eq("bad_lk_no_en", enableOut, 0);
    check_eq("bad_lk_char", lk_char, 8'h00);
    tick();
    check_eq("bad_lk_ack_err", {lk_ack, err}, 2'b11);
    lk_req = 1'b0;
    tick();

    // contention from reset: save, lookup, save, lookup
    n_rst = 1'b0;
    sv_req = 1'b1; sv_char = 8'h11; sv_path = 12'h123; sv_len = 4'd5;
    lk_req = 1'b1; lk_loc = 12'h456; lk_len = 4'd2; charOut = 8'h33;
    tick();
    tick();
    n_rst = 1'b1;
    exp_q = {1'b0, 1'b1, 1'b0, 1'b1};
    prev_in = 1'b0; prev_out = 1'b0; overlap = 0;
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      tick();
      if (enableIn && enableOut) overlap++;
      if ((enableIn && !prev_in) || (enableOut && !prev_out))
        check_eq("grant_order", enableOut, exp_q.pop_front());
      prev_in = enableIn; prev_out = enableOut;
      saveComp = enableIn; writeComp = enableOut;
    end
    check_eq("grants_missing", exp_q.size(), 0);
    // drain: each requester drops after its ack
    cyc = 0;
    while ((busy || sv_req || lk_req) && cyc < 40) begin
      tick();
      cyc++;
      if (enableIn && enableOut) overlap++;
      if (sv_ack) sv_req = 1'b0;
      if (lk_ack) lk_req = 1'b0;
      saveComp = enableIn; writeComp = enableOut;
    end
    saveComp = 1'b0; writeComp = 1'b0;
    check_eq("enable_overlap", overlap, 0);
    check_eq("drain_idle", busy, 0);
    check_eq("cont_lk_char", lk_char, 8'h33);

    // reset in the third LOOK cycle
    lk_req = 1'b1; lk_loc = 12'h0C3; lk_len = 4'd7;
    tick();
    check_eq("rl_en_out", enableOut, 1);
    tick();
    tick();
    #2 n_rst = 1'b0;
    #1;
    check_eq("rl_en_out_async", enableOut, 0);
    check_eq("rl_busy_async", busy, 0);
    check_eq("rl_lk_char", lk_char, 8'h00);
    check_eq("rl_state", state_dbg, 0);
    lk_req = 1'b0;
    acks_seen = 0;
    tick(); if (lk_ack) acks_seen++;
    tick(); if (lk_ack) acks_seen++;
    n_rst = 1'b1;
    repeat (3) begin
      tick();
      if (lk_ack) acks_seen++;
    end
    check_eq("rl_no_ack", acks_seen, 0);
    // normal save after the abort: grant, comp, DONE, ack on third edge
    sv_req = 1'b1; sv_char = 8'h7E; sv_path = 12'hABC; sv_len = 4'd2;
    got = 1'b0; cyc = 0;
    while (!got && cyc < 10) begin
      tick();
      cyc++;
      saveComp = enableIn;
      if (sv_ack) got = 1'b1;
    end
    check_eq("rl_save_ack", got, 1);
    check_eq("rl_save_lat", cyc, 3);
    sv_req = 1'b0; saveComp = 1'b0;
    tick();

`ifdef TABLE_CTRL_TIMEOUT_EN
    // timeout: enableOut held exactly TIMEOUT_CYCLES cycles, then ack+err
    lk_req = 1'b1; lk_loc = 12'h001; lk_len = 4'd4;
    got = 1'b0; cyc = 0; acks_seen = 0;
    for (int c = 0; c < 200 && !got; c++) begin
      tick();
      if (enableOut) cyc++;
      if (lk_ack) begin
        got = 1'b1;
        acks_seen = int'(err);
      end
    end
    check_eq("to_ack", got, 1);
    check_eq("to_en_cycles", cyc, 64);
    check_eq("to_err", acks_seen, 1);
    check_eq("to_lk_char", lk_char, 8'h00);
    lk_req = 1'b0;
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
